// File: rtl/coprosit_pkg.sv
// Shared types and constants for the Coprosit posit coprocessor issue path.
// Optional quire scoreboarding is selected with the COPROSIT_QUIRE_EN macro.
package coprosit_pkg;

    localparam int unsigned NUM_PREGS    = 32;
    localparam int unsigned PREG_IDX_W   = $clog2(NUM_PREGS);
    // Widest offload id the issue path can carry; narrower ids are zero-extended.
    localparam int unsigned MAX_ID_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } issue_state_e;

    typedef struct packed {
        logic [4:0]              op;
        logic [PREG_IDX_W-1:0]   rd;
        logic [PREG_IDX_W-1:0]   rs1;
        logic [PREG_IDX_W-1:0]   rs2;
        logic                    rd_we;
        logic [1:0]              rs_use;
        logic                    quire;
        logic [MAX_ID_WIDTH-1:0] id;
    } issue_req_t;

endpackage

// File: rtl/coprosit_issue_ctrl_if.sv
// Decoder-side, execution-side and completion signals of the issue controller.
// The slave modport is the controller's view; master is the environment's view.
interface coprosit_issue_ctrl_if #(
    parameter int unsigned ID_WIDTH = 4
);

    logic                in_valid_i;
    logic                in_ready_o;
    logic [4:0]          in_op_i;
    logic [4:0]          in_rd_i;
    logic [4:0]          in_rs1_i;
    logic [4:0]          in_rs2_i;
    logic                in_rd_we_i;
    logic [1:0]          in_rs_use_i;
    logic                in_quire_i;
    logic [ID_WIDTH-1:0] in_id_i;

    logic                iss_valid_o;
    logic                iss_ready_i;
    logic [4:0]          iss_op_o;
    logic [4:0]          iss_rd_o;
    logic [4:0]          iss_rs1_o;
    logic [4:0]          iss_rs2_o;
    logic [ID_WIDTH-1:0] iss_id_o;

    logic                cpl_valid_i;
    logic [4:0]          cpl_rd_i;
    logic                cpl_rd_we_i;
    logic                cpl_quire_i;

    modport slave (
        input  in_valid_i, in_op_i, in_rd_i, in_rs1_i, in_rs2_i,
               in_rd_we_i, in_rs_use_i, in_quire_i, in_id_i,
        output in_ready_o,
        output iss_valid_o, iss_op_o, iss_rd_o, iss_rs1_o, iss_rs2_o, iss_id_o,
        input  iss_ready_i,
        input  cpl_valid_i, cpl_rd_i, cpl_rd_we_i, cpl_quire_i
    );

    modport master (
        output in_valid_i, in_op_i, in_rd_i, in_rs1_i, in_rs2_i,
               in_rd_we_i, in_rs_use_i, in_quire_i, in_id_i,
        input  in_ready_o,
        input  iss_valid_o, iss_op_o, iss_rd_o, iss_rs1_o, iss_rs2_o, iss_id_o,
        output iss_ready_i,
        output cpl_valid_i, cpl_rd_i, cpl_rd_we_i, cpl_quire_i
    );

endinterface

// File: rtl/coprosit_scoreboard.sv
// Posit-register / quire busy tracking and in-flight counter for the issue controller.
// Quire tracking exists only when COPROSIT_QUIRE_EN is defined.
module coprosit_scoreboard
    import coprosit_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  issue_req_t            req_i,
    output logic                  hazard_o,
    input  logic                  set_i,
    input  logic                  clr_i,
    input  logic [PREG_IDX_W-1:0] clr_rd_i,
    input  logic                  clr_rd_we_i,
    input  logic                  clr_quire_i,
    output logic                  underflow_o,
    output logic                  outst_nz_o
);

    localparam int unsigned      CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_PREGS-1:0] pbusy_q, pbusy_d;
    logic [CNT_W-1:0]     outst_q, outst_d;
    logic                 dec;
    logic                 quire_hazard;

`ifdef COPROSIT_QUIRE_EN
    logic qbusy_q, qbusy_d;

    assign quire_hazard = req_i.quire && qbusy_q;

    always_comb begin
        qbusy_d = qbusy_q;
        if (set_i && req_i.quire) qbusy_d = 1'b1;
        if (dec && clr_quire_i)   qbusy_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) qbusy_q <= 1'b0;
        else       qbusy_q <= qbusy_d;
    end

    logic unused_req;
    assign unused_req = ^{req_i.op, req_i.id};
`else
    assign quire_hazard = 1'b0;

    logic unused_req;
    assign unused_req = ^{req_i.op, req_i.id, req_i.quire, clr_quire_i};
`endif

    assign hazard_o = (req_i.rs_use[0] && pbusy_q[req_i.rs1])
                   || (req_i.rs_use[1] && pbusy_q[req_i.rs2])
                   || (req_i.rd_we     && pbusy_q[req_i.rd])
                   || quire_hazard
                   || (outst_q == CNT_MAX);

    // A completion arriving with nothing in flight is discarded entirely.
    assign dec         = clr_i && (outst_q != '0);
    assign underflow_o = clr_i && (outst_q == '0);
    assign outst_nz_o  = (outst_q != '0);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pbusy_d = pbusy_q;
        if (set_i && req_i.rd_we) pbusy_d[req_i.rd] = 1'b1;
        if (dec && clr_rd_we_i)   pbusy_d[clr_rd_i] = 1'b0;

        outst_d = outst_q;
        unique case ({set_i, dec})
            2'b10:   outst_d = outst_q + CNT_ONE;
            2'b01:   outst_d = outst_q - CNT_ONE;
            default: outst_d = outst_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pbusy_q <= '0;
            outst_q <= '0;
        end else begin
            pbusy_q <= pbusy_d;
            outst_q <= outst_d;
        end
    end

endmodule

// File: rtl/coprosit_issue_ctrl.sv
// In-order single-entry issue controller between the offload decoder and the posit unit.
// Define COPROSIT_QUIRE_EN to scoreboard quire instructions; otherwise they are dropped with err_o.
module coprosit_issue_ctrl
    import coprosit_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned ID_WIDTH        = 4   // must not exceed MAX_ID_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    coprosit_issue_ctrl_if.slave bus_if,
    output logic                 busy_o,
    output logic                 err_o
);

    issue_state_e state_q, state_d;
    issue_req_t   req_q, req_d;
    logic         err_q, err_d;

    logic hazard;
    logic issue_hs;
    logic underflow;
    logic outst_nz;

    assign issue_hs = (state_q == ISSUE) && bus_if.iss_ready_i;

    coprosit_scoreboard #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_sb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_q),
        .hazard_o    (hazard),
        .set_i       (issue_hs),
        .clr_i       (bus_if.cpl_valid_i),
        .clr_rd_i    (bus_if.cpl_rd_i),
        .clr_rd_we_i (bus_if.cpl_rd_we_i),
        .clr_quire_i (bus_if.cpl_quire_i),
        .underflow_o (underflow),
        .outst_nz_o  (outst_nz)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            req_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        err_d   = err_q | underflow;
        unique case (state_q)
            IDLE: begin
                if (bus_if.in_valid_i) begin
                    req_d.op     = bus_if.in_op_i;
                    req_d.rd     = bus_if.in_rd_i;
                    req_d.rs1    = bus_if.in_rs1_i;
                    req_d.rs2    = bus_if.in_rs2_i;
                    req_d.rd_we  = bus_if.in_rd_we_i;
                    req_d.rs_use = bus_if.in_rs_use_i;
                    req_d.quire  = bus_if.in_quire_i;
                    req_d.id     = MAX_ID_WIDTH'(bus_if.in_id_i);
                    state_d      = WAIT;
                end
            end
            WAIT: begin
`ifdef COPROSIT_QUIRE_EN
                if (!hazard) state_d = ISSUE;
`else
                // Without quire hardware the instruction cannot execute: drop it and flag.
                if (req_q.quire) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (!hazard) begin
                    state_d = ISSUE;
                end
`endif
            end
            ISSUE: begin
                if (bus_if.iss_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decode the state register only; rst_i masks ready during reset.
    always_comb begin
        bus_if.in_ready_o  = (state_q == IDLE) && !rst_i;
        bus_if.iss_valid_o = (state_q == ISSUE);
    end

    assign bus_if.iss_op_o  = req_q.op;
    assign bus_if.iss_rd_o  = req_q.rd;
    assign bus_if.iss_rs1_o = req_q.rs1;
    assign bus_if.iss_rs2_o = req_q.rs2;
    assign bus_if.iss_id_o  = req_q.id[ID_WIDTH-1:0];

    logic unused_id;
    assign unused_id = ^req_q.id;

    assign busy_o = (state_q != IDLE) || outst_nz;
    assign err_o  = err_q;

endmodule
